// File: rtl/keypad_entry_fsm.sv
// Calculator key-entry front end: builds two signed-BCD operands and an operator from
// one-cycle key events, and pulses calc_start when '=' moves entry into the result state.
module keypad_entry_fsm #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [1:0]          stateEncoder,
  output logic [4*DIGITS:0]   operand1,
  output logic [4*DIGITS:0]   operand2,
  output logic [1:0]          operator,
  output logic                calc_start,
  output logic                key_reject
);

  localparam int MW = 4 * DIGITS;
  localparam int W  = MW + 1;
  localparam int CW = $clog2(DIGITS + 1);

  // key_valid is a one-cycle strobe with no backpressure: every cycle it is high the key
  // is consumed, and a key that cannot be applied is flagged on key_reject one cycle later.
  typedef enum logic [1:0] {
    ST_A = 2'b01,
    ST_B = 2'b10,
    ST_C = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op1_q, op1_d, op2_q, op2_d;
  logic [1:0]      opr_q, opr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d, rej_q, rej_d;

  logic [W-1:0]    cur, cur_d;
  logic [MW-1:0]   cur_mag, shifted;
  logic            cur_we;

  assign cur     = (state_q == ST_B) ? op2_q : op1_q;
  assign cur_mag = cur[MW-1:0];
  assign shifted = MW'({cur_mag, key_code});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_A;
      op1_q   <= '0;
      op2_q   <= '0;
      opr_q   <= 2'b00;
      cnt_q   <= '0;
      start_q <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opr_q   <= opr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opr_d   = opr_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    rej_d   = 1'b0;
    cur_d   = cur;
    cur_we  = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (state_q == ST_C) begin
          op1_d   = W'(key_code);
          op2_d   = '0;
          opr_d   = 2'b00;
          cnt_d   = (key_code != 4'd0) ? CW'(1) : '0;
          state_d = ST_A;
        end else if (!(cur_mag == '0 && key_code == 4'd0)) begin
          // Leading zeros are swallowed so the digit count tracks significant digits only.
          if (cnt_q == CW'(DIGITS)) begin
            rej_d = 1'b1;
          end else begin
            cur_d  = {cur[W-1], shifted};
            cur_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end else begin
        case (key_code)
          4'hA, 4'hB, 4'hC: begin
            if (state_q == ST_C) begin
              rej_d = 1'b1;
            end else begin
              opr_d = 2'(key_code - 4'd9);
              if (state_q == ST_A) begin
                op2_d   = '0;
                cnt_d   = '0;
                state_d = ST_B;
              end
            end
          end
          4'hE: begin
            if (state_q == ST_C || cur_mag == '0) begin
              rej_d = 1'b1;
            end else begin
              cur_d  = {~cur[W-1], cur_mag};
              cur_we = 1'b1;
            end
          end
          4'hD: begin
            if (state_q == ST_B) begin
              state_d = ST_C;
              start_d = 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end
          4'hF: begin
            op1_d   = '0;
            op2_d   = '0;
            opr_d   = 2'b00;
            cnt_d   = '0;
            state_d = ST_A;
          end
          default: begin
          end
        endcase
      end
    end
    if (cur_we) begin
      if (state_q == ST_B) op2_d = cur_d;
      else                 op1_d = cur_d;
    end
  end

  always_comb begin
    stateEncoder = state_q;
    operand1     = op1_q;
    operand2     = op2_q;
    operator     = opr_q;
    calc_start   = start_q;
    key_reject   = rej_q;
  end

endmodule

// File: tb/tb_keypad_entry_fsm.sv
// Bench for keypad_entry_fsm: directed vector table, async-reset sequence, and random
// key streams checked against a decimal-arithmetic reference model.
module tb_keypad_entry_fsm;

  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  stateEncoder;
  logic [12:0] operand1, operand2;
  logic [1:0]  operator;
  logic        calc_start, key_reject;

  int n_vec = 0;
  int n_err = 0;

  keypad_entry_fsm #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .stateEncoder(stateEncoder), .operand1(operand1), .operand2(operand2),
    .operator(operator), .calc_start(calc_start), .key_reject(key_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  k;
    logic [1:0]  st;
    logic [12:0] o1;
    logic [12:0] o2;
    logic [1:0]  opr;
    logic        cs;
    logic        rj;
  } vec_t;

  vec_t tbl[$];

  // reference model: operands held as decimal integers plus a sign bit
  int m_st;
  int m_mag[2];
  int m_sgn[2];
  int m_opr;
  int m_cs, m_rj;

  function automatic logic [11:0] to_bcd(input int m);
    return {4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_mag[0] = 0; m_mag[1] = 0; m_sgn[0] = 0; m_sgn[1] = 0;
    m_opr = 0; m_cs = 0; m_rj = 0;
  endtask

  task automatic model_key(input logic v, input logic [3:0] k);
    int i;
    int lim;
    lim = 1;
    for (int d = 1; d < DIGITS; d++) lim = lim * 10;
    m_cs = 0; m_rj = 0;
    i = (m_st == 1) ? 1 : 0;
    if (v) begin
      if (k <= 4'd9) begin
        if (m_st == 2) begin
          m_mag[0] = int'(k); m_sgn[0] = 0; m_mag[1] = 0; m_sgn[1] = 0; m_opr = 0; m_st = 0;
        end else if (!(m_mag[i] == 0 && k == 4'd0)) begin
          if (m_mag[i] >= lim) m_rj = 1;
          else m_mag[i] = m_mag[i] * 10 + int'(k);
        end
      end else if (k >= 4'hA && k <= 4'hC) begin
        if (m_st == 2) m_rj = 1;
        else begin
          m_opr = int'(k) - 9;
          if (m_st == 0) begin m_mag[1] = 0; m_sgn[1] = 0; m_st = 1; end
        end
      end else if (k == 4'hE) begin
        if (m_st == 2 || m_mag[i] == 0) m_rj = 1;
        else m_sgn[i] = 1 - m_sgn[i];
      end else if (k == 4'hD) begin
        if (m_st == 1) begin m_st = 2; m_cs = 1; end
        else m_rj = 1;
      end else begin
        model_reset();
      end
    end
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [12:0] o1,
                       input logic [12:0] o2, input logic [1:0] opr, input logic cs,
                       input logic rj);
    n_vec++;
    if ({stateEncoder, operand1, operand2, operator, calc_start, key_reject} !==
        {st, o1, o2, opr, cs, rj}) begin
      n_err++;
      $display("FAIL %s: got st=%b op1=%h op2=%h opr=%b cs=%b rj=%b, want st=%b op1=%h op2=%h opr=%b cs=%b rj=%b",
               name, stateEncoder, operand1, operand2, operator, calc_start, key_reject,
               st, o1, o2, opr, cs, rj);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 2'(m_st + 1), {1'(m_sgn[0]), to_bcd(m_mag[0])}, {1'(m_sgn[1]), to_bcd(m_mag[1])},
          2'(m_opr), 1'(m_cs), 1'(m_rj));
  endtask

  task automatic apply(input logic v, input logic [3:0] k);
    @(negedge clk);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    // directed table: each row is a key and the outputs expected after the next edge
    tbl.push_back('{1, 4'h1, 2'b01, 13'h0001, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h2, 2'b01, 13'h0012, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h3, 2'b01, 13'h0123, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h4, 2'b01, 13'h0123, 13'h0000, 2'b00, 0, 1});
    tbl.push_back('{0, 4'h5, 2'b01, 13'h0123, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hF, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h5, 2'b01, 13'h0005, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b01, 13'h1005, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hA, 2'b10, 13'h1005, 13'h0000, 2'b01, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b10, 13'h1005, 13'h0000, 2'b01, 0, 1});
    tbl.push_back('{1, 4'h7, 2'b10, 13'h1005, 13'h0007, 2'b01, 0, 0});
    tbl.push_back('{1, 4'hD, 2'b11, 13'h1005, 13'h0007, 2'b01, 1, 0});
    tbl.push_back('{0, 4'h0, 2'b11, 13'h1005, 13'h0007, 2'b01, 0, 0});
    tbl.push_back('{1, 4'hA, 2'b11, 13'h1005, 13'h0007, 2'b01, 0, 1});
    tbl.push_back('{1, 4'hE, 2'b11, 13'h1005, 13'h0007, 2'b01, 0, 1});
    tbl.push_back('{1, 4'hD, 2'b11, 13'h1005, 13'h0007, 2'b01, 0, 1});
    tbl.push_back('{1, 4'h9, 2'b01, 13'h0009, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hF, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h0, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h0, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 1});
    tbl.push_back('{1, 4'h4, 2'b01, 13'h0004, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h5, 2'b01, 13'h0045, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h6, 2'b01, 13'h0456, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b01, 13'h1456, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b01, 13'h0456, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hD, 2'b01, 13'h0456, 13'h0000, 2'b00, 0, 1});
    tbl.push_back('{1, 4'hA, 2'b10, 13'h0456, 13'h0000, 2'b01, 0, 0});
    tbl.push_back('{1, 4'hB, 2'b10, 13'h0456, 13'h0000, 2'b10, 0, 0});
    tbl.push_back('{1, 4'h8, 2'b10, 13'h0456, 13'h0008, 2'b10, 0, 0});
    tbl.push_back('{1, 4'hB, 2'b10, 13'h0456, 13'h0008, 2'b10, 0, 0});
    tbl.push_back('{1, 4'hE, 2'b10, 13'h0456, 13'h1008, 2'b10, 0, 0});
    tbl.push_back('{1, 4'h9, 2'b10, 13'h0456, 13'h1089, 2'b10, 0, 0});
    tbl.push_back('{1, 4'hF, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'h2, 2'b01, 13'h0002, 13'h0000, 2'b00, 0, 0});
    tbl.push_back('{1, 4'hC, 2'b10, 13'h0002, 13'h0000, 2'b11, 0, 0});
    tbl.push_back('{1, 4'h4, 2'b10, 13'h0002, 13'h0004, 2'b11, 0, 0});
    tbl.push_back('{1, 4'hD, 2'b11, 13'h0002, 13'h0004, 2'b11, 1, 0});
    tbl.push_back('{1, 4'hF, 2'b01, 13'h0000, 13'h0000, 2'b00, 0, 0});

    // clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("reset", 2'b01, 13'h0, 13'h0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].k);
      check($sformatf("table[%0d]", i), tbl[i].st, tbl[i].o1, tbl[i].o2, tbl[i].opr,
            tbl[i].cs, tbl[i].rj);
    end

    // asynchronous reset in the middle of operand2 entry, between clock edges
    apply(1'b1, 4'h7);
    apply(1'b1, 4'h8);
    apply(1'b1, 4'hA);
    apply(1'b1, 4'h3);
    check("pre_async", 2'b10, 13'h0078, 13'h0003, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 2'b01, 13'h0, 13'h0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 4'h3);
    check("post_async", 2'b01, 13'h0003, 13'h0, 2'b00, 1'b0, 1'b0);

    // randomized key stream against the reference model
    apply(1'b1, 4'hF);
    model_reset();
    check_model("rand_sync");
    for (int n = 0; n < 600; n++) begin
      logic       v;
      logic [3:0] k;
      v = ($urandom_range(0, 3) != 0);
      k = 4'($urandom_range(0, 15));
      if (k == 4'hF && $urandom_range(0, 3) != 0) k = 4'($urandom_range(0, 9));
      apply(v, k);
      model_key(v, k);
      check_model($sformatf("rand[%0d] v=%0b k=%h", n, v, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
